mem_model_bank: RTL and testbench

// - Parametrised synchronous single-port memory model; next generation of the 4x8 memory model.
// - Adds configurable width/depth, per-byte write strobes, pipelined read latency with rd_valid,
//   out-of-range detection and optional parity. Sits behind mem_intf-style driver/monitor agents as the DUT.

---
 rtl/mem_model_pkg.sv | 46 ++++
 rtl/mem_rd_pipe.sv | 56 +++++
 rtl/mem_model_bank.sv | 142 ++++++++++++++
 tb/tb_mem_model_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_model_pkg
// Purpose  : Shared constants, read-pipe entry type, parity helper and
//            parameter legality checks for the mem_model_bank memory model.
// Contents : c_RD_LAT_MAX  - deepest supported read pipe
//            c_PAR_W_MAX   - widest word the parity helper accepts
//            rd_pipe_t     - per-stage read tag {valid, oor, perr}
//            calc_parity() - even-parity bit over a (zero-extended) word
//            *_ok()        - elaboration-time parameter checks
// Revision : 1.0 - initial release
// ============================================================================
package mem_model_pkg;

    localparam int c_RD_LAT_MAX = 4;
    localparam int c_PAR_W_MAX  = 1024;

    // Tag that travels with each read through the latency pipe. The data
    // word rides alongside it in a DATA_W-wide vector so that no bits of a
    // fixed-width field are left dangling for narrow configurations.
    typedef struct packed {
        logic valid;  // an accepted read occupies this stage
        logic oor;    // the read address was >= DEPTH
        logic perr;   // stored parity did not match the stored word
    } rd_pipe_t;

    // Even parity: the returned bit makes the total count of ones even.
    // Zero-extension does not change the result, so callers pass any width.
    function automatic logic calc_parity(input logic [c_PAR_W_MAX-1:0] word);
        return ^word;
    endfunction

    function automatic bit data_w_ok(input int data_w);
        return (data_w > 0) && (data_w % 8 == 0) && (data_w <= c_PAR_W_MAX);
    endfunction

    function automatic bit depth_ok(input int depth, input int addr_w);
        return (addr_w >= 1) && (addr_w <= 30) && (depth >= 1) && (depth <= (1 << addr_w));
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat >= 1) && (rd_lat <= c_RD_LAT_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_rd_pipe
// Purpose  : RD_LAT-stage shift pipe carrying a read tag plus its data word.
//            Stage 0 captures on the request edge; the last stage is the
//            registered output. Data only advances with a valid tag, so the
//            output word holds its last value between reads.
// Ports    : clk, rst          - clock, synchronous active-high flush
//            i_tag, i_data     - entry presented for capture this edge
//            o_tag, o_data     - entry leaving the last stage
// Revision : 1.0 - initial release
// ============================================================================
module mem_rd_pipe
    import mem_model_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  rd_pipe_t          i_tag,
    input  logic [DATA_W-1:0] i_data,
    output rd_pipe_t          o_tag,
    output logic [DATA_W-1:0] o_data
);

    rd_pipe_t          r_tag  [RD_LAT];
    logic [DATA_W-1:0] r_data [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_tag[0].valid <= i_tag.valid;
            if (i_tag.valid) begin
                r_tag[0]  <= i_tag;
                r_data[0] <= i_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i].valid <= r_tag[i-1].valid;
                if (r_tag[i-1].valid) begin
                    r_tag[i]  <= r_tag[i-1];
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_tag  = r_tag[RD_LAT-1];
    assign o_data = r_data[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mem_model_bank.sv
`default_nettype none
// ============================================================================
// Module   : mem_model_bank
// Purpose  : Synchronous single-port memory model with byte strobes,
//            RD_LAT-cycle pipelined reads, out-of-range detection and
//            optional even parity (build macro MEM_MODEL_PARITY_EN).
// Ports    : clk, rst   - clock, synchronous active-high reset (clears array)
//            addr       - word address
//            wr_en      - write request; wdata/wstrb select the bytes
//            rd_en      - read request; answered RD_LAT cycles later
//            rdata      - read word, meaningful while rd_valid=1
//            rd_valid   - one pulse per accepted read
//            addr_err   - addr>=DEPTH: next cycle for writes, with rd_valid
//                         for reads
//            par_err    - stored parity mismatch, with rd_valid
// Config   : MEM_MODEL_PARITY_EN defined adds a parity bit per word and the
//            simulation hook task inject_par_flip(addr); undefined ties
//            par_err to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_model_bank
    import mem_model_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                rd_valid,
    output logic                addr_err,
    output logic                par_err
);

    localparam int c_NB = DATA_W / 8;

    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("mem_model_bank: DATA_W must be a non-zero multiple of 8");
    end
    if (!depth_ok(DEPTH, ADDR_W)) begin : g_bad_depth
        $error("mem_model_bank: DEPTH must be in 1..2**ADDR_W");
    end
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_model_bank: RD_LAT must be in 1..4");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_oor;

    logic              w_addr_ok;
    logic [DATA_W-1:0] w_cur_word;
    logic [DATA_W-1:0] w_merged;
    logic              w_rd_perr;
    rd_pipe_t          w_pipe_in;
    rd_pipe_t          w_pipe_out;
    logic [DATA_W-1:0] w_pipe_data;

    // One extra bit on the left keeps the compare exact when DEPTH == 2**ADDR_W.
    assign w_addr_ok  = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
    assign w_cur_word = w_addr_ok ? r_mem[addr] : '0;

    for (genvar b = 0; b < c_NB; b++) begin : g_byte
        assign w_merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : w_cur_word[8*b +: 8];
    end

    // The read path uses w_cur_word, sampled before this edge's write lands,
    // which gives read-first behaviour on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_oor <= 1'b0;
        end else begin
            r_wr_oor <= wr_en & ~w_addr_ok;
            if (wr_en && w_addr_ok) begin
                r_mem[addr] <= w_merged;
            end
        end
    end

`ifdef MEM_MODEL_PARITY_EN
    logic r_par [DEPTH];
    logic w_cur_par;

    // Plain always block: the injection task below also writes r_par.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_par[i] <= 1'b0;
            end
        end else if (wr_en && w_addr_ok) begin
            r_par[addr] <= calc_parity(c_PAR_W_MAX'(w_merged));
        end
    end

    assign w_cur_par = w_addr_ok ? r_par[addr] : 1'b0;
    assign w_rd_perr = w_addr_ok & (calc_parity(c_PAR_W_MAX'(w_cur_word)) != w_cur_par);

    // Simulation hook: corrupt the stored parity of one word.
    task automatic inject_par_flip(input int unsigned a);
        if (a < DEPTH) begin
            r_par[a] = ~r_par[a];
        end
    endtask
`else
    assign w_rd_perr = 1'b0;
`endif

    always_comb begin
        w_pipe_in       = '0;
        w_pipe_in.valid = rd_en;
        w_pipe_in.oor   = ~w_addr_ok;
        w_pipe_in.perr  = w_rd_perr;
    end

    mem_rd_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_tag  (w_pipe_in),
        .i_data (w_cur_word),
        .o_tag  (w_pipe_out),
        .o_data (w_pipe_data)
    );

    assign rdata    = w_pipe_data;
    assign rd_valid = w_pipe_out.valid;
    assign addr_err = r_wr_oor | (w_pipe_out.valid & w_pipe_out.oor);
    assign par_err  = w_pipe_out.valid & w_pipe_out.perr;

endmodule
`default_nettype wire

// File: tb/tb_mem_model_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_model_bank
// Purpose  : Directed, table-driven bench for mem_model_bank configured with
//            DEPTH=12 and RD_LAT=3 so out-of-range and deeper latency are
//            both exercised on one instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_model_bank;

    localparam int c_ADDR_W = 4;
    localparam int c_DEPTH  = 12;
    localparam int c_DATA_W = 32;
    localparam int c_RD_LAT = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        addr_err;
    logic        par_err;

    int total;
    int bad;

    mem_model_bank #(
        .ADDR_W (c_ADDR_W),
        .DEPTH  (c_DEPTH),
        .DATA_W (c_DATA_W),
        .RD_LAT (c_RD_LAT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .addr_err (addr_err),
        .par_err  (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock: inputs for the edge, outputs expected just after.
    typedef struct {
        logic        rst;
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_valid;
        logic        exp_err;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic we, input logic re, input logic [3:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic ev, input logic ee, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.we = we; v.re = re; v.addr = a; v.wdata = wd; v.wstrb = ws;
        v.exp_valid = ev; v.exp_err = ee; v.chk_data = ev | r; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic re, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
        rst = r; wr_en = we; rd_en = re; addr = a; wdata = wd; wstrb = ws;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    endtask

    logic [31:0] exp_mem [16];

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; wstrb = '0;

        //   rst we re addr wdata          wstrb  valid err data
        add(1, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 0 reset
        add(1, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 1
        add(0, 1, 0, 4'd3,  32'hDEADBEEF, 4'hF, 0, 0, 32'h0);         // 2
        add(1, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 3 reset clears
        add(0, 0, 1, 4'd3,  32'h0,        4'h0, 0, 0, 32'h0);         // 4 read 3
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 5
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 0, 32'h0);         // 6 <- read 3
        add(0, 1, 0, 4'd5,  32'h11223344, 4'hF, 0, 0, 32'h0);         // 7
        add(0, 1, 0, 4'd5,  32'hAABBCCDD, 4'h5, 0, 0, 32'h0);         // 8 strobes
        add(0, 0, 1, 4'd5,  32'h0,        4'h0, 0, 0, 32'h0);         // 9
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 10
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 0, 32'h11BB33DD);  // 11
        add(0, 1, 0, 4'd7,  32'h1,        4'hF, 0, 0, 32'h0);         // 12
        add(0, 1, 1, 4'd7,  32'h2,        4'hF, 0, 0, 32'h0);         // 13 collision
        add(0, 0, 1, 4'd7,  32'h0,        4'h0, 0, 0, 32'h0);         // 14
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 0, 32'h1);         // 15 read-first
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 0, 32'h2);         // 16 committed
        add(0, 1, 0, 4'd13, 32'hFFFFFFFF, 4'hF, 0, 1, 32'h0);         // 17 oor write
        add(0, 0, 1, 4'd13, 32'h0,        4'h0, 0, 0, 32'h0);         // 18 oor read
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 19
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 1, 32'h0);         // 20
        add(0, 0, 1, 4'd5,  32'h0,        4'h0, 0, 0, 32'h0);         // 21
        add(0, 0, 1, 4'd1,  32'h0,        4'h0, 0, 0, 32'h0);         // 22
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 0, 32'h11BB33DD);  // 23 unchanged
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 0, 32'h0);         // 24 no alias
        add(0, 1, 1, 4'd13, 32'h12345678, 4'hF, 0, 1, 32'h0);         // 25 both oor
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 26
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 1, 32'h0);         // 27
        add(0, 1, 0, 4'd5,  32'h0,        4'h0, 0, 0, 32'h0);         // 28 wstrb=0
        add(0, 0, 1, 4'd5,  32'h0,        4'h0, 0, 0, 32'h0);         // 29
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 30
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 0, 32'h11BB33DD);  // 31
        add(0, 1, 1, 4'd2,  32'hCAFEF00D, 4'hF, 0, 0, 32'h0);         // 32 wr 2 only
        add(0, 0, 1, 4'd2,  32'h0,        4'h0, 0, 0, 32'h0);         // 33
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 0, 0, 32'h0);         // 34
        add(0, 0, 0, 4'd0,  32'h0,        4'h0, 1, 0, 32'hCAFEF00D);  // 35

        // Vector 32 reads addr 2 as well (same address as the write), so its
        // result (old value 0) appears at vector 34.
        vecs[34].exp_valid = 1'b1;
        vecs[34].chk_data  = 1'b1;
        vecs[34].exp_data  = 32'h0;

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            check($sformatf("vec%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d addr_err", i), {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d par_err", i),  {31'b0, par_err},  32'h0);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_data);
            end
        end

        // Streaming: fill all in-range words, then read 0..15 back to back.
        for (int a = 0; a < 16; a++) begin
            exp_mem[a] = (a < c_DEPTH) ? (32'h1000_0000 + 32'(a) * 32'h0001_0101) : 32'h0;
        end
        for (int a = 0; a < c_DEPTH; a++) begin
            step(1'b0, 1'b1, 1'b0, 4'(a), exp_mem[a], 4'hF);
        end
        idle();
        for (int j = 0; j < 20; j++) begin
            if (j < 16) step(1'b0, 1'b0, 1'b1, 4'(j), 32'h0, 4'h0);
            else        idle();
            if (j >= c_RD_LAT - 1 && j < c_RD_LAT - 1 + 16) begin
                check($sformatf("stream%0d rd_valid", j), {31'b0, rd_valid}, 32'h1);
                check($sformatf("stream%0d rdata", j), rdata, exp_mem[j-(c_RD_LAT-1)]);
                check($sformatf("stream%0d addr_err", j), {31'b0, addr_err},
                      {31'b0, (j - (c_RD_LAT - 1)) >= c_DEPTH});
            end else begin
                check($sformatf("stream%0d rd_valid", j), {31'b0, rd_valid}, 32'h0);
            end
        end

        // Reset mid-read: the in-flight read must vanish.
        step(1'b0, 1'b0, 1'b1, 4'd1, 32'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        check("midrst rd_valid", {31'b0, rd_valid}, 32'h0);
        check("midrst rdata", rdata, 32'h0);
        check("midrst addr_err", {31'b0, addr_err}, 32'h0);
        check("midrst par_err", {31'b0, par_err}, 32'h0);
        for (int j = 0; j < 4; j++) begin
            idle();
            check($sformatf("midrst_after%0d rd_valid", j), {31'b0, rd_valid}, 32'h0);
        end

`ifdef MEM_MODEL_PARITY_EN
        u_dut.inject_par_flip(2);
        step(1'b0, 1'b0, 1'b1, 4'd2, 32'h0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
        idle();
        check("parflip rd_valid", {31'b0, rd_valid}, 32'h1);
        check("parflip par_err", {31'b0, par_err}, 32'h1);
        idle();
        check("parok rd_valid", {31'b0, rd_valid}, 32'h1);
        check("parok par_err", {31'b0, par_err}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
